hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Control-side counterpart to the IF/ID pipeline register: generates the `freeze` and `flush` strobes that the IF/ID register, PC register and ID/EX register consume.
- Detects RAW data hazards between the ID stage and the EXE/MEM stages, with or without forwarding.
- Squashes wrong-path instructions on taken branches.
- Tracks multi-cycle memory waits with a small FSM.
- Keeps saturating stall and flush statistics counters.

Parameters:
- REG_W, 4, register-index width (16-entry register file).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- idValid  in  1  ID stage holds a real instruction.
- src1  in  REG_W  ID first source register.
- src2  in  REG_W  ID second source register.
- twoSrc  in  1  ID instruction reads src2.
- exeDest  in  REG_W  EXE destination register.
- exeWbEn  in  1  EXE instruction writes back.
- exeMemRead  in  1  EXE instruction is a load.
- memDest  in  REG_W  MEM destination register.
- memWbEn  in  1  MEM instruction writes back.
- forwardEn  in  1  forwarding unit enabled.
- branchTaken  in  1  EXE resolved a taken branch.
- memReq  in  1  MEM stage issues a data-memory access this cycle.
- memReady  in  1  data memory completes the access this cycle.
- clrStats  in  1  synchronous clear of both counters.
- freeze  out  1  hold PC and IF/ID (drives `ld` = ~freeze).
- flush  out  1  clear IF/ID and ID/EX.
- idExBubble  out  1  clear ID/EX only (inserts a bubble).
- pipeStall  out  1  hold every pipeline register (memory wait).
- stallCnt  out  CNT_W  cycles with freeze=1.
- flushCnt  out  CNT_W  cycles with flush=1.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; stallCnt and flushCnt go to 0.
  - freeze, flush, idExBubble and pipeStall are forced to 0 while rst=1.
- FSM states:
  - IDLE: if memReq=1 and memReady=0, move to MEM_WAIT. memReq=1 and memReady=1 completes in one cycle with no stall.
  - MEM_WAIT: stay until memReady=1, then return to IDLE. memReq is ignored in this state.
- pipeStall (combinational):
  - 1 when (IDLE and memReq and ~memReady).
  - 1 in MEM_WAIT when ~memReady.
  - 0 on the memReady cycle.
- hazard (combinational, internal):
  - hz1 = exe match on src1, or mem match on src1.
  - hz2 = twoSrc and (exe match on src2, or mem match on src2).
  - hazard = idValid and (hz1 or hz2).
  - With forwardEn=0, a match is xWbEn and xDest==src.
  - With forwardEn=1, only an EXE load counts: exeMemRead and exeWbEn and exeDest==src. MEM matches are ignored.
- Priority: pipeStall > branchTaken > hazard.
  - pipeStall=1: freeze=1, flush=0, idExBubble=0. The branch is held in EXE and re-evaluated after the wait.
  - else branchTaken=1: flush=1, freeze=0, idExBubble=0. The hazard is discarded because the ID instruction is squashed.
  - else hazard=1: freeze=1, idExBubble=1.
  - otherwise all outputs are 0.
- Latency: all control outputs are combinational, valid in the same cycle as their inputs. The FSM and counters are registered.
- Counters:
  - stallCnt increments on each posedge with freeze=1; flushCnt increments on each posedge with flush=1.
  - Both saturate at all-ones and never wrap.
  - clrStats=1 zeroes both counters and takes priority over the increment in that cycle.
- Reset during MEM_WAIT returns to IDLE immediately. An access still in flight is the memory controller's responsibility.

Test Plan:
- Reset: assert rst mid-MEM_WAIT with memReq=1 → all four control outputs are 0 immediately; after release with memReq=0 → state IDLE, counters 0.
- Load-use hazard, forwardEn=1: exeMemRead=1, exeWbEn=1, exeDest=3, src1=3, idValid=1 → freeze=1, idExBubble=1 for 1 cycle. Next cycle (load moved to MEM) → freeze=0; stallCnt=1.
- No forwarding: forwardEn=0, memWbEn=1, memDest=5, src2=5, twoSrc=1 → freeze=1. Same setup with twoSrc=0 → freeze=0.
- Branch priority: hazard condition plus branchTaken=1 → flush=1, freeze=0, idExBubble=0; flushCnt increments by 1.
- Memory wait: memReq=1, memReady=0 for 3 cycles, then memReady=1 → pipeStall=1 and freeze=1 for 3 cycles, 0 on the ready cycle. branchTaken held high throughout → flush=0 during the wait, 1 on the ready cycle.
- Saturation and clear: drive freeze continuously with CNT_W=4 for 20 cycles → stallCnt=15. Pulse clrStats with freeze=1 → stallCnt=0 on that edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the IF/ID / ID/EX registers.
//
// Produces the freeze / flush / bubble / stall strobes consumed by the PC,
// IF/ID and ID/EX registers, and tracks multi-cycle data-memory accesses with
// a two-state FSM. Also keeps saturating stall and flush statistics counters.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   idValid         ID stage holds a real instruction
//   src1, src2      ID source registers; twoSrc says src2 is read
//   exeDest/WbEn    EXE destination and write-back enable; exeMemRead = load
//   memDest/WbEn    MEM destination and write-back enable
//   forwardEn       forwarding unit enabled (only load-use stalls remain)
//   branchTaken     EXE resolved a taken branch
//   memReq/Ready    data-memory request this cycle / access completes
//   clrStats        synchronous clear of both counters
//   freeze          hold PC and IF/ID
//   flush           clear IF/ID and ID/EX
//   idExBubble      clear ID/EX only
//   pipeStall       hold every pipeline register during a memory wait
//   stallCnt        saturating count of cycles with freeze=1
//   flushCnt        saturating count of cycles with flush=1

module hazard_ctrl #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             twoSrc,
    input  logic [REG_W-1:0] exeDest,
    input  logic             exeWbEn,
    input  logic             exeMemRead,
    input  logic [REG_W-1:0] memDest,
    input  logic             memWbEn,
    input  logic             forwardEn,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             clrStats,
    output logic             freeze,
    output logic             flush,
    output logic             idExBubble,
    output logic             pipeStall,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic [0:0] {StIdle, StMemWait} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_exe_src1, w_exe_src2;
    logic w_mem_src1, w_mem_src2;
    logic w_hazard;
    logic w_mem_stall;

    // With forwarding, only a load in EXE cannot be bypassed in time;
    // everything else (including MEM results) is forwarded.
    always_comb begin
        w_exe_src1 = 1'b0;
        w_exe_src2 = 1'b0;
        w_mem_src1 = 1'b0;
        w_mem_src2 = 1'b0;
        if (forwardEn) begin
            w_exe_src1 = exeMemRead && exeWbEn && (exeDest == src1);
            w_exe_src2 = exeMemRead && exeWbEn && (exeDest == src2);
        end else begin
            w_exe_src1 = exeWbEn && (exeDest == src1);
            w_exe_src2 = exeWbEn && (exeDest == src2);
            w_mem_src1 = memWbEn && (memDest == src1);
            w_mem_src2 = memWbEn && (memDest == src2);
        end
    end

    assign w_hazard = idValid && ((w_exe_src1 || w_mem_src1) ||
                                  (twoSrc && (w_exe_src2 || w_mem_src2)));

    // memReq is ignored once waiting; only memReady ends the wait.
    always_comb begin
        w_mem_stall = 1'b0;
        unique case (r_state)
            StIdle:    w_mem_stall = memReq && !memReady;
            StMemWait: w_mem_stall = !memReady;
            default:   w_mem_stall = 1'b0;
        endcase
    end

    // Priority: memory stall > taken branch > data hazard. A taken branch
    // squashes the ID instruction, so its hazard is irrelevant.
    always_comb begin
        freeze     = 1'b0;
        flush      = 1'b0;
        idExBubble = 1'b0;
        pipeStall  = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                pipeStall = 1'b1;
                freeze    = 1'b1;
            end else if (branchTaken) begin
                flush = 1'b1;
            end else if (w_hazard) begin
                freeze     = 1'b1;
                idExBubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle:    if (memReq && !memReady) r_state <= StMemWait;
                StMemWait: if (memReady) r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clrStats) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (freeze && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             idValid;
    logic [REG_W-1:0] src1, src2, exeDest, memDest;
    logic             twoSrc, exeWbEn, exeMemRead, memWbEn, forwardEn;
    logic             branchTaken, memReq, memReady, clrStats;
    logic             freeze, flush, idExBubble, pipeStall;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .idValid(idValid), .src1(src1), .src2(src2),
        .twoSrc(twoSrc), .exeDest(exeDest), .exeWbEn(exeWbEn),
        .exeMemRead(exeMemRead), .memDest(memDest), .memWbEn(memWbEn),
        .forwardEn(forwardEn), .branchTaken(branchTaken), .memReq(memReq),
        .memReady(memReady), .clrStats(clrStats), .freeze(freeze), .flush(flush),
        .idExBubble(idExBubble), .pipeStall(pipeStall), .stallCnt(stallCnt),
        .flushCnt(flushCnt)
    );

    typedef struct {
        bit rst, idValid, twoSrc, exeWbEn, exeMemRead, memWbEn, forwardEn;
        bit branchTaken, memReq, memReady, clrStats;
        int src1, src2, exeDest, memDest;
    } stim_t;

    typedef struct {
        int cyc;
        bit freeze, flush, bubble, pstall;
        int sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state: "waiting on memory" plus the two counts.
    bit m_wait = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    function automatic bit pending(stim_t s, int r);
        if (s.forwardEn) return s.exeMemRead && s.exeWbEn && (s.exeDest == r);
        return (s.exeWbEn && s.exeDest == r) || (s.memWbEn && s.memDest == r);
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   stall, hz;
        @(posedge clk);
        #1;
        rst = s.rst; idValid = s.idValid; twoSrc = s.twoSrc;
        src1 = REG_W'(s.src1); src2 = REG_W'(s.src2);
        exeDest = REG_W'(s.exeDest); memDest = REG_W'(s.memDest);
        exeWbEn = s.exeWbEn; exeMemRead = s.exeMemRead; memWbEn = s.memWbEn;
        forwardEn = s.forwardEn; branchTaken = s.branchTaken;
        memReq = s.memReq; memReady = s.memReady; clrStats = s.clrStats;
        cyc++;
        e = '{cyc: cyc, default: 0};
        if (s.rst) begin
            m_wait = 0; m_sc = 0; m_fc = 0;
        end else begin
            stall = m_wait ? !s.memReady : (s.memReq && !s.memReady);
            hz = s.idValid && (pending(s, s.src1) || (s.twoSrc && pending(s, s.src2)));
            e.pstall = stall;
            e.freeze = stall || (!s.branchTaken && hz);
            e.flush  = !stall && s.branchTaken;
            e.bubble = !stall && !s.branchTaken && hz;
            e.sc = m_sc;
            e.fc = m_fc;
            m_wait = stall;
            if (s.clrStats) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (e.freeze) m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
                if (e.flush)  m_fc = (m_fc + 1 > SAT) ? SAT : m_fc + 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("freeze",     e.cyc, int'(freeze),     int'(e.freeze));
                chk("flush",      e.cyc, int'(flush),      int'(e.flush));
                chk("idExBubble", e.cyc, int'(idExBubble), int'(e.bubble));
                chk("pipeStall",  e.cyc, int'(pipeStall),  int'(e.pstall));
                chk("stallCnt",   e.cyc, int'(stallCnt),   e.sc);
                chk("flushCnt",   e.cyc, int'(flushCnt),   e.fc);
            end
        end
    end

    initial begin
        stim_t s, ld, nf, hzb;
        rst = 1'b1; idValid = 0; src1 = '0; src2 = '0; twoSrc = 0; exeDest = '0;
        exeWbEn = 0; exeMemRead = 0; memDest = '0; memWbEn = 0; forwardEn = 0;
        branchTaken = 0; memReq = 0; memReady = 0; clrStats = 0;

        // Reset, then reset in the middle of a memory wait.
        s = idle_stim(); s.rst = 1; step(s); step(s);
        s = idle_stim(); step(s);
        s.memReq = 1; step(s); step(s);
        s.rst = 1; step(s);
        s = idle_stim(); step(s); step(s);

        // Load-use with forwarding, then the load moves to MEM.
        ld = idle_stim(); ld.forwardEn = 1; ld.idValid = 1;
        ld.exeMemRead = 1; ld.exeWbEn = 1; ld.exeDest = 3; ld.src1 = 3;
        step(ld);
        s = idle_stim(); s.forwardEn = 1; s.idValid = 1; s.src1 = 3;
        s.memDest = 3; s.memWbEn = 1; step(s);
        s = idle_stim(); step(s);

        // No forwarding: MEM writer on src2, with and without twoSrc.
        nf = idle_stim(); nf.idValid = 1; nf.memWbEn = 1; nf.memDest = 5;
        nf.src1 = 1; nf.src2 = 5; nf.twoSrc = 1;
        step(nf);
        nf.twoSrc = 0; step(nf);

        // Branch beats hazard.
        hzb = ld; hzb.branchTaken = 1; step(hzb);
        s = idle_stim(); step(s);

        // Three-cycle memory wait with a taken branch held in EXE.
        s = idle_stim(); s.memReq = 1; s.branchTaken = 1;
        step(s); step(s); step(s);
        s.memReady = 1; step(s);
        s = idle_stim(); step(s);

        // Saturation of stallCnt, then clear while freezing.
        s = idle_stim(); s.clrStats = 1; step(s);
        for (int i = 0; i < 20; i++) step(ld);
        s = ld; s.clrStats = 1; step(s);
        step(ld);
        s = idle_stim(); step(s);

        // Randomised traffic with a narrow register range to force matches.
        for (int i = 0; i < 2000; i++) begin
            s = idle_stim();
            s.rst         = ($urandom_range(0, 199) == 0);
            s.idValid     = ($urandom_range(0, 9) < 8);
            s.src1        = int'($urandom_range(0, 3));
            s.src2        = int'($urandom_range(0, 3));
            s.twoSrc      = $urandom_range(0, 1) == 1;
            s.exeDest     = int'($urandom_range(0, 3));
            s.exeWbEn     = $urandom_range(0, 1) == 1;
            s.exeMemRead  = $urandom_range(0, 2) == 0;
            s.memDest     = int'($urandom_range(0, 3));
            s.memWbEn     = $urandom_range(0, 1) == 1;
            s.forwardEn   = $urandom_range(0, 1) == 1;
            s.branchTaken = $urandom_range(0, 5) == 0;
            s.memReq      = $urandom_range(0, 3) == 0;
            s.memReady    = $urandom_range(0, 1) == 1;
            s.clrStats    = $urandom_range(0, 49) == 0;
            step(s);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", cyc, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
